// File: rtl/pipe_regfile.sv
// Two-read / two-write register file for the pipelined MIPS core with optional
// same-cycle write bypass, per-register busy scoreboard, write counter and sticky error.
module pipe_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1,
    parameter int CHECK  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      rd_addr0,
    input  logic [ADDR_W-1:0]      rd_addr1,
    output logic [DATA_W-1:0]      rd_data0,
    output logic [DATA_W-1:0]      rd_data1,
    output logic                   rd_busy0,
    output logic                   rd_busy1,
    input  logic                   wr_en0,
    input  logic [ADDR_W-1:0]      wr_addr0,
    input  logic [DATA_W-1:0]      wr_data0,
    input  logic                   wr_en1,
    input  logic [ADDR_W-1:0]      wr_addr1,
    input  logic [DATA_W-1:0]      wr_data1,
    input  logic                   alloc_en,
    input  logic [ADDR_W-1:0]      alloc_addr,
    output logic [(2**ADDR_W)-1:0] busy_vec,
    output logic [CNT_W-1:0]       wr_count,
    output logic                   err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              err_r;
    logic              v0_s;
    logic              v1_s;
    logic [DEPTH-1:0]  hit0_s;
    logic [DEPTH-1:0]  hit1_s;
    logic [DEPTH-1:0]  alloc_s;
    logic [DEPTH-1:0]  wr_hit_s;
    logic [CNT_W-1:0]  inc_s;

    // Register 0 is hardwired, so writes to it never count as valid.
    assign v0_s     = wr_en0 && (wr_addr0 != {ADDR_W{1'b0}});
    assign v1_s     = wr_en1 && (wr_addr1 != {ADDR_W{1'b0}});
    assign wr_hit_s = hit0_s | hit1_s;
    assign inc_s    = CNT_W'(v0_s) + CNT_W'(v1_s);

    // Decode valid write and alloc targets into one-hot vectors.
    always_comb begin
        hit0_s  = {DEPTH{1'b0}};
        hit1_s  = {DEPTH{1'b0}};
        alloc_s = {DEPTH{1'b0}};
        if (v0_s) begin
            hit0_s[wr_addr0] = 1'b1;
        end else begin
            hit0_s = {DEPTH{1'b0}};
        end
        if (v1_s) begin
            hit1_s[wr_addr1] = 1'b1;
        end else begin
            hit1_s = {DEPTH{1'b0}};
        end
        if (alloc_en && (alloc_addr != {ADDR_W{1'b0}})) begin
            alloc_s[alloc_addr] = 1'b1;
        end else begin
            alloc_s = {DEPTH{1'b0}};
        end
    end

    // Register array; the younger port 1 wins an address conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_r[r] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (hit1_s[r]) begin
                    mem_r[r] <= wr_data1;
                end else if (hit0_s[r]) begin
                    mem_r[r] <= wr_data0;
                end
            end
        end
    end

    // Busy scoreboard (alloc beats a same-cycle writeback) and commit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {DEPTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            busy_r <= (busy_r & ~wr_hit_s) | alloc_s;
            cnt_r  <= cnt_r + inc_s;
        end
    end

    generate
        if (CHECK != 0) begin : g_check
            // Sticky flag: a writeback hit a register with no pending producer.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    err_r <= 1'b0;
                end else if (|(wr_hit_s & ~busy_r)) begin
                    err_r <= 1'b1;
                end
            end
        end else begin : g_nocheck
            assign err_r = 1'b0;
        end
    endgenerate

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        if (reset) begin
            return {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && hit1_s[a]) begin
            return wr_data1;
        end else if ((BYPASS != 0) && hit0_s[a]) begin
            return wr_data0;
        end else begin
            return mem_r[a];
        end
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        return busy_r[a] && !((BYPASS != 0) && wr_hit_s[a]);
    endfunction

    // Combinational read ports.
    always_comb begin
        rd_data0 = read_data(rd_addr0);
        rd_data1 = read_data(rd_addr1);
        rd_busy0 = read_busy(rd_addr0);
        rd_busy1 = read_busy(rd_addr1);
    end

    assign busy_vec = busy_r;
    assign wr_count = cnt_r;
    assign err      = err_r;

endmodule

// File: tb/tb_pipe_regfile.sv
// Randomised bench for pipe_regfile: a bypassing and a non-bypassing instance share
// stimulus and are compared each cycle against an array-based reference model.
module tb_pipe_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr0, rd_addr1, wr_addr0, wr_addr1, alloc_addr;
    logic [31:0] wr_data0, wr_data1;
    logic        wr_en0, wr_en1, alloc_en;

    logic [31:0] rd_data0_b, rd_data1_b, rd_data0_n, rd_data1_n;
    logic        rd_busy0_b, rd_busy1_b, rd_busy0_n, rd_busy1_n;
    logic [31:0] busy_vec_b, busy_vec_n;
    logic [15:0] wr_count_b, wr_count_n;
    logic        err_b, err_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [15:0] m_cnt;
    logic        m_err;

    always #5 clk = ~clk;

    pipe_regfile #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0_b), .rd_data1(rd_data1_b),
        .rd_busy0(rd_busy0_b), .rd_busy1(rd_busy1_b),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .busy_vec(busy_vec_b), .wr_count(wr_count_b), .err(err_b)
    );

    pipe_regfile #(.BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0_n), .rd_data1(rd_data1_n),
        .rd_busy0(rd_busy0_n), .rd_busy1(rd_busy1_n),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .busy_vec(busy_vec_n), .wr_count(wr_count_n), .err(err_n)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit v0();
        return wr_en0 && (wr_addr0 != 5'd0);
    endfunction

    function automatic bit v1();
        return wr_en1 && (wr_addr1 != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (reset || a == 5'd0) return 32'd0;
        if (byp && v1() && wr_addr1 == a) return wr_data1;
        if (byp && v0() && wr_addr0 == a) return wr_data0;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        bit written;
        written = (v0() && wr_addr0 == a) || (v1() && wr_addr1 == a);
        if (a == 5'd0) return 1'b0;
        return m_busy[a] && !(byp && written);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 32'd0;
        m_cnt  = 16'd0;
        m_err  = 1'b0;
    endtask

    // One clock edge of the architectural rules, applied in program order.
    task automatic model_update();
        if ((v0() && !m_busy[wr_addr0]) || (v1() && !m_busy[wr_addr1])) m_err = 1'b1;
        if (v0()) begin m_regs[wr_addr0] = wr_data0; m_busy[wr_addr0] = 1'b0; end
        if (v1()) begin m_regs[wr_addr1] = wr_data1; m_busy[wr_addr1] = 1'b0; end
        if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
        m_cnt = m_cnt + 16'(v0()) + 16'(v1());
    endtask

    task automatic check_all();
        check_val("b_rd_data0", 64'(rd_data0_b), 64'(exp_rd(rd_addr0, 1'b1)));
        check_val("b_rd_data1", 64'(rd_data1_b), 64'(exp_rd(rd_addr1, 1'b1)));
        check_val("b_rd_busy0", 64'(rd_busy0_b), 64'(exp_busy(rd_addr0, 1'b1)));
        check_val("b_rd_busy1", 64'(rd_busy1_b), 64'(exp_busy(rd_addr1, 1'b1)));
        check_val("n_rd_data0", 64'(rd_data0_n), 64'(exp_rd(rd_addr0, 1'b0)));
        check_val("n_rd_data1", 64'(rd_data1_n), 64'(exp_rd(rd_addr1, 1'b0)));
        check_val("n_rd_busy0", 64'(rd_busy0_n), 64'(exp_busy(rd_addr0, 1'b0)));
        check_val("n_rd_busy1", 64'(rd_busy1_n), 64'(exp_busy(rd_addr1, 1'b0)));
        check_val("b_busy_vec", 64'(busy_vec_b), 64'(m_busy));
        check_val("n_busy_vec", 64'(busy_vec_n), 64'(m_busy));
        check_val("b_wr_count", 64'(wr_count_b), 64'(m_cnt));
        check_val("n_wr_count", 64'(wr_count_n), 64'(m_cnt));
        check_val("b_err", 64'(err_b), 64'(m_err));
        check_val("n_err", 64'(err_n), 64'(m_err));
    endtask

    task automatic idle();
        wr_en0 = 1'b0; wr_addr0 = 5'd0; wr_data0 = 32'd0;
        wr_en1 = 1'b0; wr_addr1 = 5'd0; wr_data1 = 32'd0;
        alloc_en = 1'b0; alloc_addr = 5'd0;
        rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) model_update();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    // Asynchronous reset asserted mid-cycle with the current inputs still applied.
    task automatic do_reset();
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        check_val("rst_rd_data0", 64'(rd_data0_b), 64'd0);
        check_val("rst_rd_data1", 64'(rd_data1_b), 64'd0);
        check_val("rst_busy_vec", 64'(busy_vec_b), 64'd0);
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        settle();
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-run after writing r5.
        idle(); alloc_en = 1'b1; alloc_addr = 5'd5; step();
        idle(); wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'h12345678; step();
        idle(); rd_addr0 = 5'd5; settle();
        check_val("r5_before_rst", 64'(rd_data0_b), 64'h12345678);
        do_reset();
        check_val("cnt_after_rst", 64'(wr_count_b), 64'd0);
        check_val("err_after_rst", 64'(err_b), 64'd0);

        // Basic write with same-cycle bypass.
        idle(); alloc_en = 1'b1; alloc_addr = 5'd3; step();
        idle(); wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'hDEADBEEF; rd_addr0 = 5'd3; settle();
        check_val("byp_deadbeef", 64'(rd_data0_b), 64'hDEADBEEF);
        check_val("byp_busy_drop", 64'(rd_busy0_b), 64'd0);
        check_val("nobyp_old_val", 64'(rd_data0_n), 64'd0);
        advance();
        idle(); settle();
        check_val("r3_busy_clear", 64'(busy_vec_b[3]), 64'd0);
        check_val("cnt_one", 64'(wr_count_b), 64'd1);
        check_val("err_clean", 64'(err_b), 64'd0);

        // Dual write to the same register.
        idle(); alloc_en = 1'b1; alloc_addr = 5'd7; step();
        idle(); wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h1;
        wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h2; rd_addr0 = 5'd7; settle();
        check_val("dual_bypass", 64'(rd_data0_b), 64'h2);
        advance();
        idle(); rd_addr1 = 5'd7; settle();
        check_val("dual_stored", 64'(rd_data1_n), 64'h2);
        check_val("dual_count", 64'(wr_count_b), 64'd3);

        // Alloc and write to the same register in one cycle.
        idle(); alloc_en = 1'b1; alloc_addr = 5'd9; step();
        idle(); wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'hAA;
        alloc_en = 1'b1; alloc_addr = 5'd9; step();
        idle(); rd_addr0 = 5'd9; settle();
        check_val("collide_data", 64'(rd_data0_n), 64'hAA);
        check_val("collide_busy", 64'(busy_vec_b[9]), 64'd1);
        advance();

        // Non-bypass visibility of r2.
        idle(); alloc_en = 1'b1; alloc_addr = 5'd2; step();
        idle(); wr_en1 = 1'b1; wr_addr1 = 5'd2; wr_data1 = 32'h55; rd_addr1 = 5'd2; settle();
        check_val("nb_old_r2", 64'(rd_data1_n), 64'd0);
        check_val("nb_busy_held", 64'(rd_busy1_n), 64'd1);
        advance();
        idle(); rd_addr1 = 5'd2; settle();
        check_val("nb_new_r2", 64'(rd_data1_n), 64'h55);
        check_val("nb_busy_drop", 64'(rd_busy1_n), 64'd0);
        advance();

        // Writes to r0 are ignored; a write to a non-busy register is an error.
        idle(); wr_en1 = 1'b1; wr_addr1 = 5'd0; wr_data1 = 32'hFFFFFFFF; step();
        idle(); settle();
        check_val("r0_read", 64'(rd_data0_b), 64'd0);
        check_val("r0_count", 64'(wr_count_b), 64'd5);
        check_val("r0_no_err", 64'(err_b), 64'd0);
        idle(); wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h4444; step();
        idle(); step(); step();
        settle();
        check_val("err_sticky", 64'(err_b), 64'd1);
        advance();
        do_reset();

        // Randomised traffic concentrated on a few registers to provoke conflicts.
        for (int n = 0; n < 1500; n++) begin
            wr_en0     = ($urandom_range(0, 2) == 0);
            wr_en1     = ($urandom_range(0, 2) == 0);
            alloc_en   = ($urandom_range(0, 1) == 0);
            wr_addr0   = 5'($urandom_range(0, 7));
            wr_addr1   = 5'($urandom_range(0, 7));
            alloc_addr = 5'($urandom_range(0, 7));
            rd_addr0   = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rd_addr1   = 5'($urandom_range(0, 7));
            wr_data0   = $urandom;
            wr_data1   = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
